// File: rtl/cpu_mem_bridge_if.sv
// Request/grant memory bus between the bridge (master) and the memory (slave).
interface cpu_mem_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              MemReq;
  logic              MemWe;
  logic [ADDR_W-1:0] MemAddress;
  logic [DATA_W-1:0] MemWriteData;
  logic              MemGnt;
  logic              MemRValid;
  logic [DATA_W-1:0] MemRData;

  modport master (
    output MemReq, MemWe, MemAddress, MemWriteData,
    input  MemGnt, MemRValid, MemRData
  );

  modport slave (
    input  MemReq, MemWe, MemAddress, MemWriteData,
    output MemGnt, MemRValid, MemRData
  );
endinterface

// File: rtl/cpu_mem_bridge.sv
// CPU memory-port bridge: posted write buffer with read forwarding, a
// single-outstanding read FSM and a bus timeout with a sticky error flag.
module cpu_mem_bridge #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int WBUF_DEPTH = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [ADDR_W-1:0] CpuAddress,
  input  logic [DATA_W-1:0] CpuWriteData,
  input  logic              CpuRead,
  input  logic              CpuWrite,
  output logic [DATA_W-1:0] CpuReadData,
  output logic              CpuStall,
  output logic              BusError,
  cpu_mem_bridge_if.master  mem
);

  localparam int PTR_W = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(WBUF_DEPTH + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, DRAIN, RADDR, RWAIT, RESP} state_e;

  state_e state_q, state_d;

  // write buffer: circular FIFO, head = oldest entry
  logic [WBUF_DEPTH-1:0][ADDR_W-1:0] addr_mem_q, addr_mem_d;
  logic [WBUF_DEPTH-1:0][DATA_W-1:0] data_mem_q, data_mem_d;
  logic [PTR_W-1:0]                  head_q, head_d;
  logic [CNT_W-1:0]                  count_q, count_d;

  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              err_q, err_d;

  logic              full, empty;
  logic [PTR_W-1:0]  tail;
  logic [PTR_W-1:0]  fwd_idx;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  logic              wr_req, rd_req, req;
  logic              waiting, expire;
  logic              push, pop;
  logic              stall;
  logic [DATA_W-1:0] rd_data;

  assign full  = (count_q == CNT_W'(WBUF_DEPTH));
  assign empty = (count_q == '0);
  assign tail  = PTR_W'((int'(head_q) + int'(count_q)) % WBUF_DEPTH);

  // Forwarding: walk entries oldest to youngest so the youngest match wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    for (int k = 0; k < WBUF_DEPTH; k++) begin
      fwd_idx = PTR_W'((int'(head_q) + k) % WBUF_DEPTH);
      if (k < int'(count_q) && addr_mem_q[fwd_idx] == CpuAddress) begin
        fwd_hit  = 1'b1;
        fwd_data = data_mem_q[fwd_idx];
      end
    end
  end

  // Read FSM next state, bus arbitration, timeout and CPU-facing outputs.
  always_comb begin
    state_d = state_q;
    raddr_d = raddr_q;
    rdata_d = rdata_q;
    stall   = 1'b0;
    rd_data = '0;

    // Writes drain only while no read owns the bus.
    wr_req  = !empty && (state_q == IDLE || state_q == DRAIN);
    rd_req  = (state_q == RADDR);
    req     = wr_req || rd_req;
    waiting = (req && !mem.MemGnt) || (state_q == RWAIT && !mem.MemRValid);
    expire  = waiting && (tmo_q == TMO_W'(TIMEOUT - 1));
    // A timed-out write is dropped, which is a pop like a granted one.
    pop     = wr_req && (mem.MemGnt || expire);
    // Acceptance uses the registered count: a same-cycle pop does not help.
    push    = CpuWrite && !full && (state_q == IDLE);

    unique case (state_q)
      IDLE: begin
        if (CpuWrite) begin
          stall = full;
        end else if (CpuRead) begin
          if (fwd_hit) begin
            rd_data = fwd_data;
          end else begin
            stall   = 1'b1;
            raddr_d = CpuAddress;
            state_d = empty ? RADDR : DRAIN;
          end
        end
      end
      DRAIN: begin
        stall = 1'b1;
        if (empty || (pop && count_q == CNT_W'(1))) state_d = RADDR;
      end
      RADDR: begin
        stall = 1'b1;
        if (mem.MemGnt) begin
          state_d = RWAIT;
        end else if (expire) begin
          rdata_d = '1;
          state_d = RESP;
        end
      end
      RWAIT: begin
        stall = 1'b1;
        if (mem.MemRValid) begin
          rdata_d = mem.MemRData;
          state_d = RESP;
        end else if (expire) begin
          rdata_d = '1;
          state_d = RESP;
        end
      end
      RESP: begin
        rd_data = rdata_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Restart the wait count whenever what is on the bus changes.
    if (!waiting || expire || pop || state_d != state_q) tmo_d = '0;
    else                                                  tmo_d = tmo_q + TMO_W'(1);

    err_d = err_q || expire;
  end

  // Write buffer next state.
  always_comb begin
    addr_mem_d = addr_mem_q;
    data_mem_d = data_mem_q;
    head_d     = head_q;
    if (push) begin
      addr_mem_d[tail] = CpuAddress;
      data_mem_d[tail] = CpuWriteData;
    end
    if (pop) head_d = (head_q == PTR_W'(WBUF_DEPTH - 1)) ? '0 : head_q + PTR_W'(1);
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // FSM state register.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Buffer, read latches, timeout counter and sticky error.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      addr_mem_q <= '0;
      data_mem_q <= '0;
      head_q     <= '0;
      count_q    <= '0;
      raddr_q    <= '0;
      rdata_q    <= '0;
      tmo_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      addr_mem_q <= addr_mem_d;
      data_mem_q <= data_mem_d;
      head_q     <= head_d;
      count_q    <= count_d;
      raddr_q    <= raddr_d;
      rdata_q    <= rdata_d;
      tmo_q      <= tmo_d;
      err_q      <= err_d;
    end
  end

  // Bus drives zero whenever no request is up.
  assign mem.MemReq       = req;
  assign mem.MemWe        = wr_req;
  assign mem.MemAddress   = wr_req ? addr_mem_q[head_q] : (rd_req ? raddr_q : '0);
  assign mem.MemWriteData = wr_req ? data_mem_q[head_q] : '0;

  // Never stall an idle CPU, and never while reset is held.
  assign CpuStall    = stall && (CpuRead || CpuWrite) && Rst;
  assign CpuReadData = rd_data;
  assign BusError    = err_q;

endmodule

// File: tb/tb_cpu_mem_bridge.sv
// Directed bench for cpu_mem_bridge: a bus scoreboard checks every granted
// transaction against the order the CPU issued it; a second instance with a
// short timeout covers the bus-error path.
module tb_cpu_mem_bridge;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          Clk = 1'b0;
  logic          Rst, rst_t;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_rd, cpu_wr;
  logic [DW-1:0] rdata, rdata_t;
  logic          stall, stall_t, berr, berr_t;

  int checks = 0;
  int errors = 0;
  int sc;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } xact_t;

  xact_t exp_q[$];
  xact_t mon_e;

  cpu_mem_bridge_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  cpu_mem_bridge_if #(.ADDR_W(AW), .DATA_W(DW)) busx ();

  cpu_mem_bridge #(.DATA_W(DW), .ADDR_W(AW), .WBUF_DEPTH(2), .TIMEOUT(255)) dut (
    .Clk(Clk), .Rst(Rst), .CpuAddress(cpu_addr), .CpuWriteData(cpu_wdata),
    .CpuRead(cpu_rd), .CpuWrite(cpu_wr), .CpuReadData(rdata),
    .CpuStall(stall), .BusError(berr), .mem(bus)
  );

  cpu_mem_bridge #(.DATA_W(DW), .ADDR_W(AW), .WBUF_DEPTH(2), .TIMEOUT(4)) dut_t (
    .Clk(Clk), .Rst(rst_t), .CpuAddress(cpu_addr), .CpuWriteData(cpu_wdata),
    .CpuRead(cpu_rd), .CpuWrite(cpu_wr), .CpuReadData(rdata_t),
    .CpuStall(stall_t), .BusError(berr_t), .mem(busx)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic smp();
    @(negedge Clk);
  endtask

  task automatic expect_bus(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    xact_t e;
    e.we   = we;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic drive_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    cpu_wr    = 1'b1;
    cpu_rd    = 1'b0;
    cpu_addr  = a;
    cpu_wdata = d;
  endtask

  // Scoreboard: every granted bus transaction must be the oldest expected one.
  always @(negedge Clk) begin
    if (Rst && bus.MemReq && bus.MemGnt) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL bus_unexpected observed addr=%h we=%b expected no transaction",
               bus.MemAddress, bus.MemWe);
      end
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("bus_we", 32'(bus.MemWe), 32'(mon_e.we));
        chk("bus_addr", bus.MemAddress, mon_e.addr);
        if (mon_e.we) chk("bus_wdata", bus.MemWriteData, mon_e.data);
      end
    end
    if (Rst && !bus.MemReq) chk("bus_idle_addr", bus.MemAddress, 32'h0);
  end

  initial begin
    Rst = 1'b0; rst_t = 1'b0;
    cpu_addr = '0; cpu_wdata = '0; cpu_rd = 1'b0; cpu_wr = 1'b0;
    bus.MemGnt = 1'b0; bus.MemRValid = 1'b0; bus.MemRData = '0;
    busx.MemGnt = 1'b0; busx.MemRValid = 1'b0; busx.MemRData = '0;

    // reset state
    repeat (2) cyc();
    smp();
    chk("rst_req", 32'(bus.MemReq), 0);
    chk("rst_we", 32'(bus.MemWe), 0);
    chk("rst_addr", bus.MemAddress, 0);
    chk("rst_wdata", bus.MemWriteData, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_berr", 32'(berr), 0);
    chk("rstT_req", 32'(busx.MemReq), 0);
    chk("rstT_berr", 32'(berr_t), 0);
    cyc();
    Rst = 1'b1;
    cyc();
    smp();
    chk("rel_req", 32'(bus.MemReq), 0);
    chk("rel_stall", 32'(stall), 0);
    chk("rel_berr", 32'(berr), 0);
    cyc();

    // posted write then forwarded read hit
    drive_wr(32'h10, 32'h1234);
    expect_bus(1'b1, 32'h10, 32'h1234);
    smp(); chk("t1_wr_stall", 32'(stall), 0); cyc();
    cpu_wr = 1'b0; cpu_rd = 1'b1;
    smp();
    chk("t1_req", 32'(bus.MemReq), 1);
    chk("t1_we", 32'(bus.MemWe), 1);
    chk("t1_addr", bus.MemAddress, 32'h10);
    chk("t1_hit_stall", 32'(stall), 0);
    chk("t1_hit_data", rdata, 32'h1234);
    cyc();
    cpu_rd = 1'b0; bus.MemGnt = 1'b1; cyc(); bus.MemGnt = 1'b0;

    // youngest matching entry wins
    drive_wr(32'h10, 32'h1); expect_bus(1'b1, 32'h10, 32'h1);
    smp(); chk("t2_w1_stall", 32'(stall), 0); cyc();
    drive_wr(32'h10, 32'h2); expect_bus(1'b1, 32'h10, 32'h2);
    smp(); chk("t2_w2_stall", 32'(stall), 0); cyc();
    cpu_wr = 1'b0; cpu_rd = 1'b1;
    smp(); chk("t2_fwd_data", rdata, 32'h2); chk("t2_fwd_stall", 32'(stall), 0); cyc();
    cpu_rd = 1'b0; bus.MemGnt = 1'b1; repeat (2) cyc(); bus.MemGnt = 1'b0;
    smp(); chk("t2_drained", 32'(bus.MemReq), 0); cyc();

    // read miss on empty buffer: immediate grant, data one cycle later
    sc = 0;
    cpu_rd = 1'b1; cpu_addr = 32'h40;
    expect_bus(1'b0, 32'h40, 32'h0);
    smp(); sc += int'(stall); chk("t3_idle_req", 32'(bus.MemReq), 0); cyc();
    bus.MemGnt = 1'b1;
    smp(); sc += int'(stall); cyc();
    bus.MemGnt = 1'b0; bus.MemRValid = 1'b1; bus.MemRData = 32'hCAFEF00D;
    smp(); sc += int'(stall); cyc();
    bus.MemRValid = 1'b0;
    smp(); sc += int'(stall);
    chk("t3_data", rdata, 32'hCAFEF00D);
    chk("t3_resp_stall", 32'(stall), 0);
    cyc();
    cpu_rd = 1'b0;
    chk("t3_stall_cycles", sc, 3);

    // full buffer stalls the third write until a pop has registered
    drive_wr(32'h100, 32'hA1); expect_bus(1'b1, 32'h100, 32'hA1);
    smp(); chk("t4_w1_stall", 32'(stall), 0); cyc();
    drive_wr(32'h104, 32'hA2); expect_bus(1'b1, 32'h104, 32'hA2);
    smp(); chk("t4_w2_stall", 32'(stall), 0); cyc();
    drive_wr(32'h108, 32'hA3);
    smp(); chk("t4_w3_full_stall", 32'(stall), 1); cyc();
    bus.MemGnt = 1'b1;
    smp(); chk("t4_w3_pop_stall", 32'(stall), 1); cyc();
    bus.MemGnt = 1'b0; expect_bus(1'b1, 32'h108, 32'hA3);
    smp(); chk("t4_w3_accept", 32'(stall), 0); cyc();
    cpu_wr = 1'b0; bus.MemGnt = 1'b1; repeat (2) cyc(); bus.MemGnt = 1'b0;
    smp(); chk("t4_drained", 32'(bus.MemReq), 0); cyc();

    // read miss with two pending writes: writes drain first
    drive_wr(32'h200, 32'hB1); expect_bus(1'b1, 32'h200, 32'hB1);
    smp(); cyc();
    drive_wr(32'h204, 32'hB2); expect_bus(1'b1, 32'h204, 32'hB2);
    smp(); cyc();
    sc = 0;
    cpu_wr = 1'b0; cpu_rd = 1'b1; cpu_addr = 32'h80;
    expect_bus(1'b0, 32'h80, 32'h0);
    smp(); sc += int'(stall); chk("t5_drain_we", 32'(bus.MemWe), 1); cyc();
    bus.MemGnt = 1'b1;
    repeat (3) begin smp(); sc += int'(stall); cyc(); end
    bus.MemGnt = 1'b0; bus.MemRValid = 1'b1; bus.MemRData = 32'h55AA55AA;
    smp(); sc += int'(stall); cyc();
    bus.MemRValid = 1'b0;
    smp();
    chk("t5_data", rdata, 32'h55AA55AA);
    chk("t5_resp_stall", 32'(stall), 0);
    cyc();
    cpu_rd = 1'b0;
    chk("t5_stall_cycles", sc, 5);
    chk("t5_sb_empty", exp_q.size(), 0);

    // timeout instance: MemGnt never comes
    rst_t = 1'b1;
    repeat (2) cyc();
    sc = 0;
    cpu_rd = 1'b1; cpu_addr = 32'h300;
    for (int i = 0; i < 5; i++) begin
      smp();
      sc += int'(stall_t);
      if (i == 4) chk("t6_berr_before", 32'(berr_t), 0);
      cyc();
    end
    smp();
    chk("t6_berr", 32'(berr_t), 1);
    chk("t6_data", rdata_t, 32'hFFFFFFFF);
    chk("t6_resp_stall", 32'(stall_t), 0);
    cyc();
    chk("t6_stall_cycles", sc, 5);
    cpu_rd = 1'b0;
    repeat (3) cyc();
    smp();
    chk("t6_berr_sticky", 32'(berr_t), 1);
    chk("t6_main_inflight", 32'(bus.MemReq), 1);

    // asynchronous reset mid-operation clears everything at once
    #2;
    Rst = 1'b0; rst_t = 1'b0;
    #1;
    chk("mid_req", 32'(bus.MemReq), 0);
    chk("mid_addr", bus.MemAddress, 0);
    chk("midT_berr", 32'(berr_t), 0);
    chk("midT_rdata", rdata_t, 0);
    chk("midT_stall", 32'(stall_t), 0);
    chk("midT_req", 32'(busx.MemReq), 0);
    cyc();
    Rst = 1'b1; rst_t = 1'b1;
    // stale read data after reset must be ignored
    bus.MemRValid = 1'b1; bus.MemRData = 32'hDEADBEEF;
    cyc();
    bus.MemRValid = 1'b0;
    smp();
    chk("post_req", 32'(bus.MemReq), 0);
    chk("post_rdata", rdata, 0);
    chk("post_stall", 32'(stall), 0);
    chk("post_berrT", 32'(berr_t), 0);
    cyc();
    chk("final_sb_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
